// File: rtl/osc_dump_uart_tx.sv
// osc_dump_uart_tx
//   Drains a finished capture buffer and streams it to the host as a framed
//   UART 8N1 dump: header byte, status byte {7'b0, trig_flag}, then DEPTH
//   samples in read order. A dump starts on a falling edge of cap_busy seen
//   while idle. While a dump runs, further edges are ignored.
//
// Parameters
//   DW       sample width, must be 8 (one UART byte per sample)
//   DEPTH    samples read per dump
//   CLK_DIV  clk cycles per UART bit, >= 2
//   HDR      frame header byte
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   cap_busy   capture engine busy; its 1->0 edge starts a dump
//   trig_flag  1 = triggered capture, 0 = timeout; latched on the start cycle
//   din        buffer sample, valid the cycle after read
//   read       one-cycle read strobe to the capture buffer
//   tx         UART serial output, idle high
//   active     high from dump start to the end of the last stop bit
//   done       one-cycle pulse when the last stop bit completes
`timescale 1ns/1ps
module osc_dump_uart_tx #(
  parameter int          DW      = 8,
  parameter int          DEPTH   = 1000,
  parameter int          CLK_DIV = 868,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_busy,
  input  logic          trig_flag,
  input  logic [DW-1:0] din,
  output logic          read,
  output logic          tx,
  output logic          active,
  output logic          done
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST_SMP  = CW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BAUD = BW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    SEND_STAT,
    RD_REQ,
    RD_CAP,
    SEND_SMP
  } state_t;

  state_t        state;
  logic          busy_q;     // previous cap_busy, for edge detection
  logic          trig_q;     // trig_flag captured at dump start
  logic [9:0]    shreg;      // {stop, byte, start}; bit 0 is the bit on the line
  logic [3:0]    bit_cnt;    // 0..9 within the current byte
  logic [BW-1:0] baud_cnt;   // 0..CLK_DIV-1 within the current bit
  logic [CW-1:0] smp_cnt;    // samples sent so far in this dump

  logic sending;
  logic start;

  assign sending = (state == SEND_HDR) || (state == SEND_STAT) || (state == SEND_SMP);
  assign start   = (state == IDLE) && busy_q && !cap_busy;

  // NOTE: every register here, outputs included, is assigned with <= so all
  // of them update together on the edge; a blocking assignment would let a
  // later statement see the new value within the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      trig_q   <= 1'b0;
      shreg    <= '1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      smp_cnt  <= '0;
      read     <= 1'b0;
      tx       <= 1'b1;
      active   <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy_q <= cap_busy;
      read   <= 1'b0;
      done   <= 1'b0;

      if (sending) begin
        if (baud_cnt == LAST_BAUD) begin
          baud_cnt <= '0;
          if (bit_cnt == 4'd9) begin
            // Stop bit finished: the next line state starts on the very next cycle.
            bit_cnt <= '0;
            case (state)
              SEND_HDR: begin
                state <= SEND_STAT;
                shreg <= {1'b1, 7'b0, trig_q, 1'b0};
                tx    <= 1'b0;
              end
              SEND_STAT: begin
                state <= RD_REQ;
                read  <= 1'b1;
                tx    <= 1'b1;
              end
              default: begin  // SEND_SMP
                smp_cnt <= smp_cnt + 1'b1;
                tx      <= 1'b1;
                if (smp_cnt < LAST_SMP) begin
                  state <= RD_REQ;
                  read  <= 1'b1;
                end else begin
                  state  <= IDLE;
                  done   <= 1'b1;
                  active <= 1'b0;
                end
              end
            endcase
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            shreg   <= {1'b1, shreg[9:1]};
            tx      <= shreg[1];
          end
        end else begin
          baud_cnt <= baud_cnt + 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= SEND_HDR;
              trig_q   <= trig_flag;
              smp_cnt  <= '0;
              bit_cnt  <= '0;
              baud_cnt <= '0;
              active   <= 1'b1;
              shreg    <= {1'b1, HDR, 1'b0};
              tx       <= 1'b0;
            end
          end
          // read was raised on entry and drops here; the buffer answers next cycle.
          RD_REQ: state <= RD_CAP;
          RD_CAP: begin
            state <= SEND_SMP;
            shreg <= {1'b1, din, 1'b0};
            tx    <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osc_dump_uart_tx.sv
`timescale 1ns/1ps
module tb_osc_dump_uart_tx;

  localparam int         D0  = 8;
  localparam int         CD0 = 4;
  localparam int         D1  = 1000;
  localparam int         CD1 = 2;    // long-dump instance uses a short bit time
  localparam logic [7:0] HDR = 8'hA5;
  localparam int         ACT0 = (D0 + 2) * 10 * CD0 + 2 * D0;
  localparam int         ACT1 = (D1 + 2) * 10 * CD1 + 2 * D1;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy0, trig0, busy1, trig1;
  logic [7:0] din0 = '0, din1 = '0;
  logic       read0, tx0, act0, done0;
  logic       read1, tx1, act1, done1;

  osc_dump_uart_tx #(.DW(8), .DEPTH(D0), .CLK_DIV(CD0), .HDR(HDR)) dut0 (
    .clk(clk), .rst(rst), .cap_busy(busy0), .trig_flag(trig0), .din(din0),
    .read(read0), .tx(tx0), .active(act0), .done(done0));

  osc_dump_uart_tx #(.DW(8), .DEPTH(D1), .CLK_DIV(CD1), .HDR(HDR)) dut1 (
    .clk(clk), .rst(rst), .cap_busy(busy1), .trig_flag(trig1), .din(din1),
    .read(read1), .tx(tx1), .active(act1), .done(done1));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Capture buffer models: data appears the cycle after a read strobe.
  logic [7:0] mem0 [D0];
  logic [7:0] mem1 [D1];
  int ptr0 = 0, ptr1 = 0;

  always @(posedge clk) begin
    if (!act0) ptr0 <= 0;
    else if (read0) begin
      din0 <= mem0[ptr0 % D0];
      ptr0 <= ptr0 + 1;
    end
  end

  always @(posedge clk) begin
    if (!act1) ptr1 <= 0;
    else if (read1) begin
      din1 <= mem1[ptr1 % D1];
      ptr1 <= ptr1 + 1;
    end
  end

  // Event counters, sampled on the falling edge.
  int rd_n0 = 0, dn_n0 = 0, act_n0 = 0, stray0 = 0;
  int rd_n1 = 0, dn_n1 = 0, act_n1 = 0, stray1 = 0;

  always @(negedge clk) begin
    if (read0 === 1'b1) rd_n0++;
    if (done0 === 1'b1) dn_n0++;
    if (act0 === 1'b1) act_n0++;
    if (read0 === 1'b1 && act0 !== 1'b1) stray0++;
    if (read1 === 1'b1) rd_n1++;
    if (done1 === 1'b1) dn_n1++;
    if (act1 === 1'b1) act_n1++;
    if (read1 === 1'b1 && act1 !== 1'b1) stray1++;
  end

  // UART receivers: mid-bit sampling, framing errors counted.
  logic [7:0] rx_q0[$];
  logic [7:0] rx_q1[$];
  int fe_n0 = 0, fe_n1 = 0;

  function automatic logic txv(input int which);
    return (which == 0) ? tx0 : tx1;
  endfunction

  task automatic uart_rx(input int which, input int cd);
    logic [7:0] b;
    int fe;
    forever begin
      @(negedge clk);
      if (txv(which) === 1'b0) begin
        fe = 0;
        b  = '0;
        repeat (cd / 2) @(negedge clk);
        if (txv(which) !== 1'b0) fe = 1;
        for (int i = 0; i < 8; i++) begin
          repeat (cd) @(negedge clk);
          b[i] = txv(which);
        end
        repeat (cd) @(negedge clk);
        if (txv(which) !== 1'b1) fe = 1;
        if (which == 0) begin
          rx_q0.push_back(b);
          fe_n0 += fe;
        end else begin
          rx_q1.push_back(b);
          fe_n1 += fe;
        end
      end
    end
  endtask

  initial uart_rx(0, CD0);
  initial uart_rx(1, CD1);

  typedef struct {
    int rx, rd, dn, act, fe;
  } snap_t;

  function automatic snap_t take_snap(input int which);
    snap_t s;
    if (which == 0) s = '{rx_q0.size(), rd_n0, dn_n0, act_n0, fe_n0};
    else            s = '{rx_q1.size(), rd_n1, dn_n1, act_n1, fe_n1};
    return s;
  endfunction

  task automatic kick(input int which, input logic trig);
    @(negedge clk);
    if (which == 0) begin busy0 = 1'b1; trig0 = trig; end
    else            begin busy1 = 1'b1; trig1 = trig; end
    repeat (3) @(negedge clk);
    if (which == 0) busy0 = 1'b0;
    else            busy1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input string tag, input int budget);
    int n = 0;
    int base = (which == 0) ? dn_n0 : dn_n1;
    while (((which == 0) ? dn_n0 : dn_n1) == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, (n < budget), 1);
    repeat (4) @(negedge clk);
  endtask

  // Reference frame: header, status, then every buffer entry in order.
  task automatic dump_checks(input int which, input string tag, input logic trig,
                             input snap_t s, input int exp_reads, input int exp_act);
    logic [7:0] exp[$];
    snap_t e;
    int d = (which == 0) ? D0 : D1;
    exp.push_back(HDR);
    exp.push_back({7'b0, trig});
    for (int k = 0; k < d; k++) exp.push_back((which == 0) ? mem0[k] : mem1[k]);
    e = take_snap(which);
    check({tag, "_len"}, e.rx - s.rx, exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (s.rx + i < e.rx)
        check($sformatf("%s_b%0d", tag, i),
              (which == 0) ? rx_q0[s.rx + i] : rx_q1[s.rx + i], exp[i]);
    end
    check({tag, "_reads"}, e.rd - s.rd, exp_reads);
    check({tag, "_dones"}, e.dn - s.dn, 1);
    check({tag, "_active"}, e.act - s.act, exp_act);
    check({tag, "_framing"}, e.fe - s.fe, 0);
  endtask

  task automatic fill0(input int mode, input logic [7:0] base);
    for (int k = 0; k < D0; k++) begin
      case (mode)
        0:       mem0[k] = base + 8'(k);
        1:       mem0[k] = base;
        default: mem0[k] = 8'($urandom);
      endcase
    end
  endtask

  typedef struct {
    logic       trig;
    int         mode;       // 0 ramp from fill, 1 constant fill, 2 random
    logic [7:0] fill;
    int         exp_reads;
    int         exp_act;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v, input int idx);
    snap_t s;
    fill0(v.mode, v.fill);
    s = take_snap(0);
    kick(0, v.trig);
    wait_done(0, $sformatf("v%0d", idx), 2000);
    dump_checks(0, $sformatf("v%0d", idx), v.trig, s, v.exp_reads, v.exp_act);
  endtask

  task automatic run_len(input logic level, output int n);
    n = 0;
    while (tx0 === level && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    snap_t s;
    int bad, n, got, len;
    logic lvl;
    logic [9:0] fr;
    int exp_runs[$];

    vecs.push_back('{1'b1, 0, 8'h00, D0, ACT0});
    vecs.push_back('{1'b0, 1, 8'h80, D0, ACT0});
    vecs.push_back('{1'b1, 1, 8'hFF, D0, ACT0});
    vecs.push_back('{1'b0, 0, 8'hF8, D0, ACT0});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{1'($urandom), 2, 8'h00, D0, ACT0});

    // Reset held while cap_busy toggles.
    rst = 1'b0; busy0 = 1'b0; trig0 = 1'b0; busy1 = 1'b0; trig1 = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      busy0 = i[0];
      busy1 = ~i[0];
      if (tx0 !== 1'b1 || read0 !== 1'b0 || act0 !== 1'b0 || done0 !== 1'b0) bad++;
      if (tx1 !== 1'b1 || read1 !== 1'b0 || act1 !== 1'b0 || done1 !== 1'b0) bad++;
    end
    check("reset_hold_outputs", bad, 0);
    busy0 = 1'b0; busy1 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("no_start_after_reset_reads", rd_n0, 0);
    check("no_start_after_reset_active", act_n0, 0);
    check("idle_tx_high", tx0, 1);

    // Table-driven dumps.
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Bit widths on the line: header runs derived from HDR's frame bits.
    fr = {1'b1, HDR, 1'b0};
    len = 1;
    for (int i = 1; i < 10; i++) begin
      if (fr[i] == fr[i-1]) len++;
      else begin
        exp_runs.push_back(len * CD0);
        len = 1;
      end
    end
    fill0(1, 8'h80);
    s = take_snap(0);
    kick(0, 1'b0);
    n = 0;
    while (tx0 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("hdr_start_bit_low", tx0, 0);
    lvl = 1'b0;
    for (int r = 0; r < 5; r++) begin
      run_len(lvl, got);
      check($sformatf("hdr_run%0d", r), got, exp_runs[r]);
      lvl = ~lvl;
    end
    wait_done(0, "runs", 2000);
    dump_checks(0, "runs", 1'b0, s, D0, ACT0);

    // Second cap_busy fall mid-dump is ignored, nothing is queued.
    fill0(0, 8'h10);
    s = take_snap(0);
    kick(0, 1'b1);
    repeat (100) @(negedge clk);
    busy0 = 1'b1;
    repeat (3) @(negedge clk);
    busy0 = 1'b0;
    wait_done(0, "refall", 2000);
    dump_checks(0, "refall", 1'b1, s, D0, ACT0);
    s = take_snap(0);
    repeat (60) @(negedge clk);
    check("refall_no_requeue_active", act_n0 - s.act, 0);
    check("refall_no_requeue_reads", rd_n0 - s.rd, 0);
    run_vec('{1'b0, 0, 8'h40, D0, ACT0}, 100);

    // Asynchronous reset in the middle of the sample stream.
    fill0(0, 8'h20);
    s = take_snap(0);
    kick(0, 1'b1);
    n = 0;
    while (rd_n0 - s.rd < 3 && n < 1000) begin @(negedge clk); n++; end
    check("midreset_reached_sample3", rd_n0 - s.rd, 3);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_tx", tx0, 1);
    check("midreset_active", act0, 0);
    check("midreset_read", read0, 0);
    check("midreset_done", done0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s = take_snap(0);
    repeat (60) @(negedge clk);
    check("postreset_reads", rd_n0 - s.rd, 0);
    check("postreset_dones", dn_n0 - s.dn, 0);
    check("postreset_active", act_n0 - s.act, 0);
    run_vec('{1'b1, 0, 8'h30, D0, ACT0}, 200);

    // Full-depth dump of a sine table.
    for (int k = 0; k < D1; k++)
      mem1[k] = 8'($rtoi(128.0 + 127.0 * $sin(6.283185307179586 * k / 1000.0)));
    s = take_snap(1);
    kick(1, 1'($urandom));
    wait_done(1, "sine", 40000);
    dump_checks(1, "sine", trig1, s, D1, ACT1);

    check("stray_reads_dut0", stray0, 0);
    check("stray_reads_dut1", stray1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
